// File: rtl/tmc_spi_pkg.sv
// Shared frame geometry and controller state encoding for the TMC-style SPI responder.
package tmc_spi_pkg;

  localparam int unsigned FRAME_BITS = 40;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STATUS_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_FETCH  = 2'd3
  } state_e;

endpackage

// File: rtl/tmc_spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI input, with a one-clk toggle flag
// (o_edge) that marks the clk cycle in which the synchronized level changed.
module tmc_spi_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_d,
  output logic o_q,
  output logic o_edge
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  // Synchronizer chain plus one extra flop holding the previous synchronized level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_chain <= {STAGES{RST_VAL}};
      r_prev  <= RST_VAL;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign o_q    = r_chain[STAGES-1];
  assign o_edge = r_chain[STAGES-1] ^ r_prev;

endmodule

// File: rtl/tmc_spi_responder.sv
// SPI mode-3 responder for 40-bit TMC datagrams: status + pipelined read data out,
// register write or read-fetch strobes in the clk domain.
module tmc_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = tmc_spi_pkg::FRAME_BITS
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sclk,
  input  logic        csn,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [7:0]  status,
  output logic [6:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [31:0] reg_rdata,
  output logic        frame_done,
  output logic        frame_err
);

  import tmc_spi_pkg::state_e;
  import tmc_spi_pkg::ST_IDLE;
  import tmc_spi_pkg::ST_SHIFT;
  import tmc_spi_pkg::ST_COMMIT;
  import tmc_spi_pkg::ST_FETCH;
  import tmc_spi_pkg::ADDR_W;
  import tmc_spi_pkg::DATA_W;
  import tmc_spi_pkg::STATUS_W;

  localparam int unsigned     CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic w_sclk_q, w_sclk_edge, w_csn_q, w_csn_edge, w_mosi_q, w_mosi_edge;

  tmc_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .resetn(resetn), .i_d(sclk), .o_q(w_sclk_q), .o_edge(w_sclk_edge)
  );
  tmc_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .clk(clk), .resetn(resetn), .i_d(csn), .o_q(w_csn_q), .o_edge(w_csn_edge)
  );
  tmc_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .resetn(resetn), .i_d(mosi), .o_q(w_mosi_q), .o_edge(w_mosi_edge)
  );

  logic w_sclk_rise, w_sclk_fall, w_csn_rise, w_csn_fall, w_mosi_bit;

  assign w_sclk_rise = w_sclk_edge & w_sclk_q;
  assign w_sclk_fall = w_sclk_edge & ~w_sclk_q;
  assign w_csn_rise  = w_csn_edge & w_csn_q;
  assign w_csn_fall  = w_csn_edge & ~w_csn_q;
  // If mosi toggles in the same cycle sclk rises, keep the level that was set up before the edge.
  assign w_mosi_bit  = w_mosi_q ^ w_mosi_edge;

  state_e                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic [FRAME_BITS-1:0]   r_rx_sh, w_rx_nxt;
  logic [FRAME_BITS-1:0]   r_tx_sh, w_tx_nxt;
  logic [FRAME_BITS-1:0]   w_load;
  logic [DATA_W-1:0]       r_rd_buf, w_rd_buf_nxt;
  logic [ADDR_W-1:0]       r_reg_addr, w_addr_nxt;
  logic [DATA_W-1:0]       r_reg_wdata, w_wdata_nxt;
  logic                    r_reg_we, w_we_nxt;
  logic                    r_reg_re, w_re_nxt;
  logic                    r_frame_done, w_done_nxt;
  logic                    r_frame_err, w_err_nxt;
  logic                    r_miso_oe;

  // Output shifter image at frame start: status byte first, then last fetched read data.
  always_comb begin
    w_load = '0;
    w_load[FRAME_BITS-1 -: (STATUS_W + DATA_W)] = {status, r_rd_buf};
  end

  // Next-state and next-output logic of the frame controller.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_rx_nxt      = r_rx_sh;
    w_tx_nxt      = r_tx_sh;
    w_rd_buf_nxt  = r_rd_buf;
    w_addr_nxt    = r_reg_addr;
    w_wdata_nxt   = r_reg_wdata;
    w_we_nxt      = 1'b0;
    w_re_nxt      = 1'b0;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_csn_fall) begin
          w_state_nxt   = ST_SHIFT;
          w_tx_nxt      = w_load;
          w_rx_nxt      = '0;
          w_bit_cnt_nxt = '0;
        end else begin
          w_tx_nxt = '0;
        end
      end
      ST_SHIFT: begin
        if (w_csn_rise) begin
          w_tx_nxt = '0;
          if (r_bit_cnt == CNT_FULL) begin
            w_state_nxt = ST_COMMIT;
          end else begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b1;
          end
        end else if (w_sclk_rise) begin
          w_rx_nxt = {r_rx_sh[FRAME_BITS-2:0], w_mosi_bit};
          if (r_bit_cnt != CNT_SAT) begin
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          end else begin
            w_bit_cnt_nxt = r_bit_cnt;
          end
        // The leading sclk fall of mode 3 precedes the first sample, so bit 39 is held through it.
        end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
          w_tx_nxt = {r_tx_sh[FRAME_BITS-2:0], 1'b0};
        end else begin
          w_tx_nxt = r_tx_sh;
        end
      end
      ST_COMMIT: begin
        w_addr_nxt = r_rx_sh[FRAME_BITS-2 -: ADDR_W];
        if (r_rx_sh[FRAME_BITS-1]) begin
          w_we_nxt    = 1'b1;
          w_wdata_nxt = r_rx_sh[DATA_W-1:0];
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_re_nxt    = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // reg_rdata answers in the clk after the strobe, so wait out the strobe cycle first.
        if (r_reg_re) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_rd_buf_nxt = reg_rdata;
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_rx_sh      <= '0;
      r_tx_sh      <= '0;
      r_rd_buf     <= '0;
      r_reg_addr   <= '0;
      r_reg_wdata  <= '0;
      r_reg_we     <= 1'b0;
      r_reg_re     <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_miso_oe    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_rx_sh      <= w_rx_nxt;
      r_tx_sh      <= w_tx_nxt;
      r_rd_buf     <= w_rd_buf_nxt;
      r_reg_addr   <= w_addr_nxt;
      r_reg_wdata  <= w_wdata_nxt;
      r_reg_we     <= w_we_nxt;
      r_reg_re     <= w_re_nxt;
      r_frame_done <= w_done_nxt;
      r_frame_err  <= w_err_nxt;
      r_miso_oe    <= ~w_csn_q;
    end
  end

  assign miso       = r_tx_sh[FRAME_BITS-1];
  assign miso_oe    = r_miso_oe;
  assign reg_addr   = r_reg_addr;
  assign reg_wdata  = r_reg_wdata;
  assign reg_we     = r_reg_we;
  assign reg_re     = r_reg_re;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_tmc_spi_responder.sv
// Directed bench for tmc_spi_responder: a mode-3 SPI master task plus a small register-file model.
module tb_tmc_spi_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sclk, csn, mosi;
  logic        miso, miso_oe;
  logic [7:0]  status;
  logic [6:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we, reg_re;
  logic [31:0] reg_rdata;
  logic        frame_done, frame_err;

  tmc_spi_responder #(.SYNC_STAGES(2), .FRAME_BITS(40)) dut (
    .clk(clk), .resetn(resetn), .sclk(sclk), .csn(csn), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .status(status),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_we = 0, n_re = 0, n_done = 0, n_err = 0;
  int s_we = 0, s_re = 0, s_done = 0, s_err = 0;
  logic [6:0]  last_waddr = 7'd0, last_raddr = 7'd0;
  logic [31:0] last_wdata = 32'd0;
  logic [31:0] mem [0:127];
  bit          wr_valid [0:127];

  // Register file model: unwritten addresses read back as 0xC0DE00<addr>.
  always @(posedge clk) begin
    if (reg_we) begin
      n_we               <= n_we + 1;
      last_waddr         <= reg_addr;
      last_wdata         <= reg_wdata;
      mem[reg_addr]      <= reg_wdata;
      wr_valid[reg_addr] <= 1'b1;
    end
    if (reg_re) begin
      n_re       <= n_re + 1;
      last_raddr <= reg_addr;
      reg_rdata  <= wr_valid[reg_addr] ? mem[reg_addr] : (32'hC0DE0000 | {25'd0, reg_addr});
    end
    if (frame_done) n_done <= n_done + 1;
    if (frame_err)  n_err  <= n_err + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_counts(input string tag, input int we, input int re, input int done, input int err);
    check_eq({tag, "_we"},   64'(n_we - s_we),     64'(we));
    check_eq({tag, "_re"},   64'(n_re - s_re),     64'(re));
    check_eq({tag, "_done"}, 64'(n_done - s_done), 64'(done));
    check_eq({tag, "_err"},  64'(n_err - s_err),   64'(err));
    s_we = n_we; s_re = n_re; s_done = n_done; s_err = n_err;
  endtask

  // One SPI frame, MSB first; miso sampled at each sclk rise. abort_at >= 0 pulses resetn mid-frame.
  task automatic spi_frame(input logic [63:0] data, input int nbits, input int abort_at, input int gap,
                           output logic [63:0] cap, output logic oe_ok);
    bit aborted = 1'b0;
    cap   = 64'd0;
    oe_ok = 1'b1;
    @(negedge clk);
    csn = 1'b0;
    #40;
    for (int j = 0; j < nbits; j++) begin
      if (j == abort_at) begin
        resetn = 1'b0;
        #20;
        csn = 1'b1; sclk = 1'b1; mosi = 1'b0;
        #20;
        resetn = 1'b1;
        #40;
        aborted = 1'b1;
        break;
      end
      sclk = 1'b0;
      mosi = data[nbits-1-j];
      #40;
      sclk  = 1'b1;
      cap   = {cap[62:0], miso};
      oe_ok = oe_ok & miso_oe;
      #40;
    end
    if (!aborted) begin
      if (nbits > 40) check_eq("cnt_sat", 64'(dut.r_bit_cnt), 64'd41);
      csn  = 1'b1;
      mosi = 1'b0;
      #30;
      check_eq("miso_idle", {62'd0, miso, miso_oe}, 64'd0);
      #(10 * gap - 30);
    end
  endtask

  logic [63:0] cap;
  logic        oe;

  initial begin
    resetn = 1'b0; csn = 1'b1; sclk = 1'b1; mosi = 1'b0; status = 8'h0F;
    #35;
    check_eq("rst_miso",  64'(miso), 64'd0);
    check_eq("rst_oe",    64'(miso_oe), 64'd0);
    check_eq("rst_we",    64'(reg_we), 64'd0);
    check_eq("rst_re",    64'(reg_re), 64'd0);
    check_eq("rst_done",  64'(frame_done), 64'd0);
    check_eq("rst_err",   64'(frame_err), 64'd0);
    check_eq("rst_addr",  64'(reg_addr), 64'd0);
    check_eq("rst_wdata", 64'(reg_wdata), 64'd0);
    resetn = 1'b1;
    #40;

    spi_frame(64'hA1000186A0, 40, -1, 12, cap, oe);
    check_eq("f1_miso", cap, 64'h0F00000000);
    check_eq("f1_oe", 64'(oe), 64'd1);
    check_counts("f1", 1, 0, 1, 0);
    check_eq("f1_addr", 64'(last_waddr), 64'h21);
    check_eq("f1_wdata", 64'(last_wdata), 64'h000186A0);

    spi_frame(64'hA112345678, 40, -1, 12, cap, oe);
    check_eq("f2_miso", cap, 64'h0F00000000);
    check_counts("f2", 1, 0, 1, 0);
    check_eq("f2_wdata", 64'(last_wdata), 64'h12345678);

    spi_frame(64'h2100000000, 40, -1, 12, cap, oe);
    check_eq("f3_miso", cap, 64'h0F00000000);
    check_counts("f3", 0, 1, 1, 0);
    check_eq("f3_raddr", 64'(last_raddr), 64'h21);

    spi_frame(64'h2100000000, 40, -1, 12, cap, oe);
    check_eq("f4_miso", cap, 64'h0F12345678);
    check_counts("f4", 0, 1, 1, 0);

    spi_frame(64'h50FFFFFFFF, 39, -1, 12, cap, oe);
    check_eq("f5_miso39", cap, 64'h07891A2B3C);
    check_counts("f5", 0, 0, 0, 1);

    spi_frame(64'h0500000000, 40, -1, 12, cap, oe);
    check_eq("f6_miso", cap, 64'h0F12345678);
    check_counts("f6", 0, 1, 1, 0);
    check_eq("f6_raddr", 64'(last_raddr), 64'h05);

    status = 8'hA5;
    spi_frame(64'hA1DEADBEEF00, 48, -1, 12, cap, oe);
    check_eq("f7_miso48", cap, 64'hA5C0DE000500);
    check_counts("f7", 0, 0, 0, 1);

    spi_frame(64'h0600000000, 40, -1, 12, cap, oe);
    check_eq("f8_miso", cap, 64'hA5C0DE0005);
    check_counts("f8", 0, 1, 1, 0);

    status = 8'h3C;
    spi_frame(64'hAA11112222, 40, 20, 12, cap, oe);
    check_eq("f9_addr_rst", 64'(reg_addr), 64'd0);
    check_counts("f9", 0, 0, 0, 0);

    spi_frame(64'h0700000000, 40, -1, 12, cap, oe);
    check_eq("f10_miso", cap, 64'h3C00000000);
    check_counts("f10", 0, 1, 1, 0);

    spi_frame(64'hAA0BADF00D, 40, -1, 4, cap, oe);
    check_eq("b2b1_miso", cap, 64'h3CC0DE0007);
    spi_frame(64'h2A00000000, 40, -1, 4, cap, oe);
    check_eq("b2b2_miso", cap, 64'h3CC0DE0007);
    spi_frame(64'h2A00000000, 40, -1, 4, cap, oe);
    check_eq("b2b3_miso", cap, 64'h3C0BADF00D);
    #100;
    check_counts("b2b", 1, 2, 3, 0);
    check_eq("b2b_wdata", 64'(last_wdata), 64'h0BADF00D);
    check_eq("b2b_waddr", 64'(last_waddr), 64'h2A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
